// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the RAM arbiter slice: default RAM geometry,
//   the requester index type and the tag that travels with each granted
//   access into the one-cycle response pipeline.
package ram_arbiter_pkg;

    localparam int DEPTH_DEF = 3584;   // implemented RAM words
    localparam int AW_DEF    = 12;     // word address width
    localparam int DW_DEF    = 32;     // data width

    // Requester index: 0 = primary (CPU), 1 = secondary (loader/DMA).
    typedef logic port_t;

    // Captured on every grant, consumed the following cycle.
    typedef struct packed {
        port_t port;       // which requester owns the response
        logic  was_read;   // reads produce rvalid, writes do not
        logic  oor;        // address was at or beyond the RAM depth
    } rsp_tag_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. A lone requester is granted immediately;
//   under contention the port that was not granted most recently wins.
//   The "last granted" register only moves when a grant is issued, so a
//   request that is withdrawn before being served leaves no trace.
// Ports:
//   clk      - clock, rising edge
//   reset_b  - asynchronous active-low reset (last = port 1 so port 0
//              wins the first contention)
//   req[1:0] - request per port
//   gnt[1:0] - combinational one-hot (or zero) grant
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_b,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_t last_reg;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_reg == 1'b1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            last_reg <= 1'b1;
        end else if (|gnt) begin
            last_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port synchronous block RAM between a primary (p0)
//   and a secondary (p1) requester. One access is granted per cycle,
//   round-robin under contention. Read data returns one cycle after the
//   grant on the shared rdata bus, qualified by the owning port's rvalid.
//   Addresses at or above DEPTH are granted but never reach the RAM; a
//   read of such an address returns zero with err, a write yields a lone
//   err pulse the following cycle.
// Ports:
//   clk, reset_b                 - clock / asynchronous active-low reset
//   pN_req/rnw/addr/wdata        - request side of port N (held until gnt)
//   pN_gnt                       - combinational grant
//   pN_rvalid, pN_err            - response flags, one cycle after grant
//   rdata                        - shared read data
//   ram_cs/rnw/address/din       - combinational drive to the RAM
//   ram_dout                     - registered read data from the RAM
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_b,

    input  logic          p0_req,
    input  logic          p0_rnw,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_rnw,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic          p1_err,

    output logic [DW-1:0] rdata,

    output logic          ram_cs,
    output logic          ram_rnw,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

    logic [1:0] req_vec;
    logic [1:0] gnt_vec;
    logic [1:0] rvalid_vec;
    logic [1:0] err_vec;

    port_t      sel;
    logic       any_gnt;
    logic       in_range;
    logic       sel_rnw;

    logic       valid_reg;
    rsp_tag_t   tag_reg;

    assign req_vec = {p1_req, p0_req};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_b (reset_b),
        .req     (req_vec),
        .gnt     (gnt_vec)
    );

    assign p0_gnt  = gnt_vec[0];
    assign p1_gnt  = gnt_vec[1];
    assign any_gnt = |gnt_vec;

    // With no grant the mux rests on port 0; only cs and rnw are forced idle.
    assign sel         = gnt_vec[1];
    assign sel_rnw     = (sel == 1'b1) ? p1_rnw   : p0_rnw;
    assign ram_address = (sel == 1'b1) ? p1_addr  : p0_addr;
    assign ram_din     = (sel == 1'b1) ? p1_wdata : p0_wdata;
    assign ram_rnw     = any_gnt ? sel_rnw : 1'b1;

    assign in_range = ({1'b0, ram_address} < DEPTH_EXT);
    assign ram_cs   = any_gnt & in_range;

    // Response pipeline: one tag per grant, cleared on idle cycles so a
    // response never repeats.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
        end else if (any_gnt) begin
            valid_reg        <= 1'b1;
            tag_reg.port     <= sel;
            tag_reg.was_read <= sel_rnw;
            tag_reg.oor      <= ~in_range;
        end else begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
        end
    end

    // Out-of-range reads never touched the RAM, so its dout is stale.
    assign rdata = tag_reg.oor ? '0 : ram_dout;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign rvalid_vec[gi] = valid_reg & tag_reg.was_read
                                    & (tag_reg.port == port_t'(gi));
            assign err_vec[gi]    = valid_reg & tag_reg.oor
                                    & (tag_reg.port == port_t'(gi));
        end
    endgenerate

    assign p0_rvalid = rvalid_vec[0];
    assign p1_rvalid = rvalid_vec[1];
    assign p0_err    = err_vec[0];
    assign p1_err    = err_vec[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a behavioural 3584 x 32 RAM
//   attached to the RAM-side ports. Inputs change 1 ns after a rising
//   edge, combinational outputs are sampled on the falling edge and
//   registered outputs 1 ns after the next rising edge.
module tb_ram_arbiter;

    localparam int DEPTH = 3584;
    localparam int AW    = 12;
    localparam int DW    = 32;

    logic          clk;
    logic          reset_b;
    logic          p0_req, p0_rnw, p1_req, p1_rnw;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p0_err;
    logic          p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] rdata;
    logic          ram_cs, ram_rnw;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_din, ram_dout;

    int total = 0;
    int bad   = 0;

    ram_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .p0_req      (p0_req),
        .p0_rnw      (p0_rnw),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_gnt      (p0_gnt),
        .p0_rvalid   (p0_rvalid),
        .p0_err      (p0_err),
        .p1_req      (p1_req),
        .p1_rnw      (p1_rnw),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_gnt      (p1_gnt),
        .p1_rvalid   (p1_rvalid),
        .p1_err      (p1_err),
        .rdata       (rdata),
        .ram_cs      (ram_cs),
        .ram_rnw     (ram_rnw),
        .ram_address (ram_address),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // Single-port synchronous RAM; dout holds when not read.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (!ram_rnw) mem[ram_address] <= ram_din;
            else          ram_dout <= mem[ram_address];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_rnw = 1'b1; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_rnw = 1'b1; p1_addr = '0; p1_wdata = '0;
    endtask

    initial begin
        idle_inputs();
        reset_b = 1'b1;
        #1 reset_b = 1'b0;
        step();
        step();
        chk("rst p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst p0_err",    32'(p0_err),    32'd0);
        chk("rst p1_err",    32'(p1_err),    32'd0);
        chk("rst ram_cs",    32'(ram_cs),    32'd0);
        chk("rst ram_rnw",   32'(ram_rnw),   32'd1);
        reset_b = 1'b1;
        step();

        // ---- reset then single read ----
        p0_req = 1'b1; p0_rnw = 1'b0; p0_addr = 12'h005; p0_wdata = 32'hDEADBEEF;
        #4;
        chk("wr5 p0_gnt",   32'(p0_gnt),      32'd1);
        chk("wr5 p1_gnt",   32'(p1_gnt),      32'd0);
        chk("wr5 ram_cs",   32'(ram_cs),      32'd1);
        chk("wr5 ram_rnw",  32'(ram_rnw),     32'd0);
        chk("wr5 ram_addr", 32'(ram_address), 32'h005);
        step();
        chk("wr5 no rvalid", 32'(p0_rvalid), 32'd0);
        p0_rnw = 1'b1;
        #4;
        chk("rd5 p0_gnt", 32'(p0_gnt), 32'd1);
        step();
        p0_req = 1'b0;
        chk("rd5 p0_rvalid", 32'(p0_rvalid), 32'd1);
        chk("rd5 p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rd5 rdata",     rdata,          32'hDEADBEEF);

        // ---- out-of-range ----
        p0_req = 1'b1; p0_rnw = 1'b0; p0_addr = 12'hDFF; p0_wdata = 32'hCAFEF00D;
        step();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_rnw = 1'b0; p1_addr = 12'hE00; p1_wdata = 32'h12345678;
        #4;
        chk("oorw p1_gnt", 32'(p1_gnt), 32'd1);
        chk("oorw ram_cs", 32'(ram_cs), 32'd0);
        step();
        chk("oorw p1_err",    32'(p1_err),    32'd1);
        chk("oorw p1_rvalid", 32'(p1_rvalid), 32'd0);
        p1_rnw = 1'b1; p1_addr = 12'hFFF;
        #4;
        chk("oorr ram_cs", 32'(ram_cs), 32'd0);
        step();
        chk("oorr p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("oorr p1_err",    32'(p1_err),    32'd1);
        chk("oorr rdata",     rdata,          32'h0);
        p1_addr = 12'hDFF;
        #4;
        chk("rdDFF ram_cs", 32'(ram_cs), 32'd1);
        step();
        p1_req = 1'b0;
        chk("rdDFF p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("rdDFF p1_err",    32'(p1_err),    32'd0);
        chk("rdDFF rdata",     rdata,          32'hCAFEF00D);
        step();
        chk("oor err one-shot", 32'(p1_err), 32'd0);

        // ---- contention alternation (last granted was p1) ----
        p0_req = 1'b1; p0_rnw = 1'b1; p0_addr = 12'h005;
        p1_req = 1'b1; p1_rnw = 1'b1; p1_addr = 12'hDFF;
        for (int i = 0; i < 4; i++) begin
            logic exp0;
            exp0 = (i % 2 == 0);
            #4;
            chk($sformatf("alt%0d p0_gnt", i), 32'(p0_gnt), 32'(exp0));
            chk($sformatf("alt%0d p1_gnt", i), 32'(p1_gnt), 32'(!exp0));
            step();
            chk($sformatf("alt%0d p0_rvalid", i), 32'(p0_rvalid), 32'(exp0));
            chk($sformatf("alt%0d p1_rvalid", i), 32'(p1_rvalid), 32'(!exp0));
            chk($sformatf("alt%0d rdata", i), rdata, exp0 ? 32'hDEADBEEF : 32'hCAFEF00D);
        end
        idle_inputs();

        // ---- read-after-write, other port ----
        p0_req = 1'b1; p0_rnw = 1'b0; p0_addr = 12'h100; p0_wdata = 32'hA5A5A5A5;
        step();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_rnw = 1'b1; p1_addr = 12'h100;
        #4;
        chk("raw p1_gnt", 32'(p1_gnt), 32'd1);
        step();
        p1_req = 1'b0;
        chk("raw p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("raw rdata",     rdata,          32'hA5A5A5A5);

        // ---- request withdrawn (last = p1, so p0 wins) ----
        p0_req = 1'b1; p0_rnw = 1'b1; p0_addr = 12'h005;
        p1_req = 1'b1; p1_rnw = 1'b1; p1_addr = 12'h100;
        #4;
        chk("wd p0_gnt", 32'(p0_gnt), 32'd1);
        chk("wd p1_gnt", 32'(p1_gnt), 32'd0);
        step();
        p0_req = 1'b0; p1_req = 1'b0;
        chk("wd p0_rvalid", 32'(p0_rvalid), 32'd1);
        #4;
        chk("wd idle p1_gnt", 32'(p1_gnt), 32'd0);
        chk("wd idle ram_cs", 32'(ram_cs), 32'd0);
        step();
        chk("wd p1_rvalid", 32'(p1_rvalid), 32'd0);
        // last must still point at p0, so p1 wins the next contention.
        p0_req = 1'b1; p1_req = 1'b1;
        #4;
        chk("wd next p1_gnt", 32'(p1_gnt), 32'd1);
        chk("wd next p0_gnt", 32'(p0_gnt), 32'd0);
        step();
        idle_inputs();
        chk("wd next p1_rvalid", 32'(p1_rvalid), 32'd1);

        // ---- async reset mid-read ----
        p0_req = 1'b1; p0_rnw = 1'b1; p0_addr = 12'h005;
        step();                       // p0 granted, last -> p0
        chk("ar pre p0_rvalid", 32'(p0_rvalid), 32'd1);
        #4;
        chk("ar p0_gnt", 32'(p0_gnt), 32'd1);
        #2 reset_b = 1'b0;            // between the grant and its response edge
        p0_req = 1'b0;
        step();
        chk("ar p0_rvalid", 32'(p0_rvalid), 32'd0);
        reset_b = 1'b1;
        step();
        chk("ar post p0_rvalid", 32'(p0_rvalid), 32'd0);
        p0_req = 1'b1; p1_req = 1'b1;
        #4;
        chk("ar cont p0_gnt", 32'(p0_gnt), 32'd1);
        chk("ar cont p1_gnt", 32'(p1_gnt), 32'd0);
        step();
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
